// File: rtl/regwb_pkg.sv
// Shared types and sizing for the register-file writeback scheduler.
// Optional starvation guard is enabled with the REGWB_STARVE_GUARD_EN macro.
package regwb_pkg;

   localparam int WIDTH        = 32;
   localparam int DEPTH        = 32;
   localparam int ADR_W        = $clog2(DEPTH);
   localparam int FIFO_DEPTH   = 2;
   localparam int STARVE_LIMIT = 4;

   // One buffered secondary result: destination register plus data.
   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic [WIDTH-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regwb_fifo.sv
// Small synchronous FIFO of secondary writeback entries with full/empty flags.
// Caller guarantees no push when full and no pop when empty; both are masked anyway.
module regwb_fifo
   import regwb_pkg::*;
#(
   parameter int DEPTH_N = FIFO_DEPTH
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  wb_entry_t din,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int PTR_W = (DEPTH_N > 1) ? $clog2(DEPTH_N) : 1;
   localparam int CNT_W = $clog2(DEPTH_N + 1);

   wb_entry_t        mem [DEPTH_N];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH_N - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH_N));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; push and pop may coincide when not full.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk) begin
      // NOTE: storage arrays are deliberately left out of reset; empty/full flags gate every read.
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between the WB stage (primary)
// and buffered long-latency results (secondary), and tracks busy destinations.
// Define REGWB_STARVE_GUARD_EN to force a FIFO drain after STARVE_LIMIT primary wins.
module regfile_wb_scheduler
   import regwb_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             P_WE,
   input  logic [ADR_W-1:0] P_ADR,
   input  logic [WIDTH-1:0] P_DATA,
   input  logic             S_VALID,
   output logic             S_READY,
   input  logic [ADR_W-1:0] S_ADR,
   input  logic [WIDTH-1:0] S_DATA,
   input  logic             S_ISSUE,
   input  logic [ADR_W-1:0] S_ISSUE_ADR,
   input  logic [ADR_W-1:0] RS1_ADR,
   input  logic [ADR_W-1:0] RS2_ADR,
   output logic             HAZARD,
   output logic             WB_STALL,
   output logic             REGWRITE,
   output logic [ADR_W-1:0] ADR_WR_REG,
   output logic [WIDTH-1:0] WR_DATA
);

   wb_entry_t        head;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             grant_p;
   logic             forced_drain;
   logic [DEPTH-1:0] busy;

   regwb_fifo #(.DEPTH_N(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ('{adr: S_ADR, data: S_DATA}),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   assign S_READY = rst && !full;
   assign push    = S_VALID && S_READY;
   assign grant_p = rst && P_WE && !forced_drain;
   assign pop     = rst && !grant_p && !empty;

`ifdef REGWB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   logic [SC_W-1:0] starve_cnt;

   // Count primary wins while the FIFO waits; any pop restarts the count.
   always_ff @(posedge clk) begin
      if (!rst)                                                  starve_cnt <= '0;
      else if (pop)                                              starve_cnt <= '0;
      else if (grant_p && !empty && starve_cnt < SC_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
   end

   assign forced_drain = !empty && (starve_cnt >= SC_W'(STARVE_LIMIT));
   assign WB_STALL     = rst && P_WE && forced_drain;
`else
   assign forced_drain = 1'b0;
   assign WB_STALL     = 1'b0;
`endif

   // Write-port mux: primary when granted, otherwise the FIFO head, otherwise idle.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      REGWRITE   = 1'b0;
      ADR_WR_REG = '0;
      WR_DATA    = '0;
      if (grant_p) begin
         REGWRITE   = 1'b1;
         ADR_WR_REG = P_ADR;
         WR_DATA    = P_DATA;
      end else if (pop) begin
         REGWRITE   = 1'b1;
         ADR_WR_REG = head.adr;
         WR_DATA    = head.data;
      end
   end

   // Busy scoreboard: clear on head pop, set on issue; the later set overrides a same-address clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         if (pop) busy[head.adr] <= 1'b0;
         // NOTE: the last non-blocking assignment to a bit wins, which gives set priority over clear.
         if (S_ISSUE && S_ISSUE_ADR != '0) busy[S_ISSUE_ADR] <= 1'b1;
      end
   end

   assign HAZARD = rst && ((RS1_ADR != '0 && busy[RS1_ADR]) ||
                           (RS2_ADR != '0 && busy[RS2_ADR]));

endmodule
